stoch_signed_stream_decoder: RTL and testbench

- Downstream stage of the stochastic signed max-pool layer.
- Takes NUM_CH signed bitstream pairs (x_p, x_m), one pair per pooled output, and integrates (x_p − x_m) over a fixed window of WINDOW cycles.
- Emits one signed binary count per channel through a valid/ready output buffer.
- Used to read back layer results for checking and for handing off to binary logic.

---
 rtl/stoch_signed_stream_decoder_pkg.sv | 25 ++
 rtl/stoch_signed_stream_decoder_if.sv | 26 ++
 rtl/stoch_signed_stream_decoder_counter.sv | 38 +++
 rtl/stoch_signed_stream_decoder.sv | 137 +++++++++++++
 tb/tb_stoch_signed_stream_decoder.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/stoch_signed_stream_decoder_pkg.sv
// Shared definitions for the stochastic signed stream decoder.
// Covers the decoder state encoding, the count-width rule and the per-cycle delta helper.
package stoch_signed_stream_decoder_pkg;

    typedef enum logic [0:0] {
        DEC_IDLE = 1'b0,
        DEC_RUN  = 1'b1
    } dec_state_e;

    // One extra bit over the magnitude so that +/-WINDOW both fit as signed values.
    function automatic int calc_acc_w(input int window);
        return $clog2(window + 1) + 1;
    endfunction

    function automatic logic signed [1:0] signed_delta(input logic p, input logic m);
        logic signed [1:0] d;
        case ({p, m})
            2'b10:   d = 2'sb01;
            2'b01:   d = 2'sb11;
            default: d = 2'sb00;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/stoch_signed_stream_decoder_if.sv
// Result handshake bundle of the signed stream decoder.
// The master produces packed signed counts; the slave consumes them.
interface stoch_signed_stream_decoder_if
    import stoch_signed_stream_decoder_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int ACC_W  = calc_acc_w(256)
);

    logic [NUM_CH*ACC_W-1:0] y_val;
    logic                    y_valid;
    logic                    y_ready;

    modport master (
        output y_val,
        output y_valid,
        input  y_ready
    );

    modport slave (
        input  y_val,
        input  y_valid,
        output y_ready
    );

endinterface

// File: rtl/stoch_signed_stream_decoder_counter.sv
// Single-channel signed up/down accumulator for one (p, m) stream pair.
// The sum output includes the current cycle's delta, so the window end can snapshot it.
module stoch_signed_counter
    import stoch_signed_stream_decoder_pkg::*;
#(
    parameter int ACC_W = 10
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    en,
    input  logic                    clr,
    input  logic                    p,
    input  logic                    m,
    output logic signed [ACC_W-1:0] sum
);

    logic signed [1:0]       delta_s;
    logic signed [ACC_W-1:0] delta_ext_s;
    logic signed [ACC_W-1:0] acc_r;

    assign delta_s     = signed_delta(p, m);
    assign delta_ext_s = {{(ACC_W-2){delta_s[1]}}, delta_s};
    assign sum         = acc_r + delta_ext_s;

    // Accumulate while enabled; clear wins over accumulate.
    always_ff @(posedge CLK) begin
        if (RST) begin
            acc_r <= {ACC_W{1'b0}};
        end else if (clr) begin
            acc_r <= {ACC_W{1'b0}};
        end else if (en) begin
            acc_r <= sum;
        end else begin
            acc_r <= acc_r;
        end
    end

endmodule

// File: rtl/stoch_signed_stream_decoder.sv
// Integrates NUM_CH signed bitstream pairs over WINDOW cycles.
// Each window's counts go to a one-entry valid/ready buffer.
module stoch_signed_stream_decoder
    import stoch_signed_stream_decoder_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int WINDOW     = 256,
    parameter bit CONTINUOUS = 1'b1
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         start,
    input  logic                         stop,
    input  logic [NUM_CH-1:0]            x_p,
    input  logic [NUM_CH-1:0]            x_m,
    stoch_signed_stream_decoder_if.master y,
    output logic                         busy,
    output logic                         overrun
);

    localparam int                ACC_W     = calc_acc_w(WINDOW);
    localparam int                WCNT_W    = $clog2(WINDOW);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WINDOW - 1);
    localparam logic [WCNT_W-1:0] WCNT_ONE  = WCNT_W'(1);

    dec_state_e              state_r;
    logic [WCNT_W-1:0]       wcnt_r;
    logic [NUM_CH*ACC_W-1:0] y_val_r;
    logic                    y_valid_r;

    logic                    run_s;
    logic                    last_s;
    logic                    en_s;
    logic                    clr_s;
    logic                    snap_s;
    logic                    consume_s;
    logic [NUM_CH*ACC_W-1:0] snap_vec_s;

    assign run_s     = (state_r == DEC_RUN);
    assign last_s    = run_s && (wcnt_r == WCNT_LAST);
    // stop overrides everything in RUN, including a coinciding last sample.
    assign en_s      = run_s && !stop;
    assign clr_s     = run_s && (stop || last_s);
    assign snap_s    = last_s && !stop;
    assign consume_s = y_valid_r && y.y_ready;

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            logic signed [ACC_W-1:0] sum_s;

            stoch_signed_counter #(
                .ACC_W (ACC_W)
            ) u_cnt (
                .CLK (CLK),
                .RST (RST),
                .en  (en_s),
                .clr (clr_s),
                .p   (x_p[i]),
                .m   (x_m[i]),
                .sum (sum_s)
            );

            assign snap_vec_s[i*ACC_W +: ACC_W] = sum_s;
        end
    endgenerate

    // Control FSM with window counter and registered busy flag.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= DEC_IDLE;
            wcnt_r  <= {WCNT_W{1'b0}};
            busy    <= 1'b0;
        end else begin
            case (state_r)
                DEC_IDLE: begin
                    wcnt_r <= {WCNT_W{1'b0}};
                    if (start && !stop) begin
                        state_r <= DEC_RUN;
                        busy    <= 1'b1;
                    end else begin
                        state_r <= DEC_IDLE;
                        busy    <= 1'b0;
                    end
                end
                DEC_RUN: begin
                    if (stop) begin
                        state_r <= DEC_IDLE;
                        wcnt_r  <= {WCNT_W{1'b0}};
                        busy    <= 1'b0;
                    end else if (wcnt_r == WCNT_LAST) begin
                        wcnt_r <= {WCNT_W{1'b0}};
                        if (CONTINUOUS) begin
                            state_r <= DEC_RUN;
                            busy    <= 1'b1;
                        end else begin
                            state_r <= DEC_IDLE;
                            busy    <= 1'b0;
                        end
                    end else begin
                        state_r <= DEC_RUN;
                        wcnt_r  <= wcnt_r + WCNT_ONE;
                        busy    <= 1'b1;
                    end
                end
                default: begin
                    state_r <= DEC_IDLE;
                    wcnt_r  <= {WCNT_W{1'b0}};
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    // One-entry output buffer; a snapshot meeting a full, unconsumed buffer is dropped.
    always_ff @(posedge CLK) begin
        if (RST) begin
            y_val_r   <= {(NUM_CH*ACC_W){1'b0}};
            y_valid_r <= 1'b0;
            overrun   <= 1'b0;
        end else if (snap_s) begin
            if (!y_valid_r || y.y_ready) begin
                y_val_r   <= snap_vec_s;
                y_valid_r <= 1'b1;
            end else begin
                overrun   <= 1'b1;
            end
        end else if (consume_s) begin
            y_valid_r <= 1'b0;
        end else begin
            y_valid_r <= y_valid_r;
        end
    end

    assign y.y_val   = y_val_r;
    assign y.y_valid = y_valid_r;

endmodule

// File: tb/tb_stoch_signed_stream_decoder.sv
// Scoreboard bench for the signed stream decoder: one-shot and continuous instances,
// expected counts summed from the driven bits and checked on each accepted result.
module tb_stoch_signed_stream_decoder;

    localparam int NC  = 2;
    localparam int WIN = 8;
    localparam int AW  = 5;
    localparam int YW  = NC * AW;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic [1:0]    start_v = 2'b00;
    logic [1:0]    stop_v  = 2'b00;
    logic [1:0]    ready_v = 2'b00;
    logic [NC-1:0] x_p = '0;
    logic [NC-1:0] x_m = '0;
    logic          busy0, busy1, ovr0, ovr1;

    logic [YW-1:0] q0[$];
    logic [YW-1:0] q1[$];
    int            vectors     = 0;
    int            miscompares = 0;

    stoch_signed_stream_decoder_if #(.NUM_CH(NC), .ACC_W(AW)) yif0();
    stoch_signed_stream_decoder_if #(.NUM_CH(NC), .ACC_W(AW)) yif1();

    assign yif0.y_ready = ready_v[0];
    assign yif1.y_ready = ready_v[1];

    stoch_signed_stream_decoder #(.NUM_CH(NC), .WINDOW(WIN), .CONTINUOUS(1'b0)) dut_once (
        .CLK(CLK), .RST(RST), .start(start_v[0]), .stop(stop_v[0]),
        .x_p(x_p), .x_m(x_m), .y(yif0), .busy(busy0), .overrun(ovr0)
    );

    stoch_signed_stream_decoder #(.NUM_CH(NC), .WINDOW(WIN), .CONTINUOUS(1'b1)) dut_cont (
        .CLK(CLK), .RST(RST), .start(start_v[1]), .stop(stop_v[1]),
        .x_p(x_p), .x_m(x_m), .y(yif1), .busy(busy1), .overrun(ovr1)
    );

    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [YW-1:0] pack2(input int c0, input int c1);
        logic [AW-1:0] a, b;
        a = c0[AW-1:0];
        b = c1[AW-1:0];
        return {b, a};
    endfunction

    function automatic logic get_valid(input int s);
        return (s == 0) ? yif0.y_valid : yif1.y_valid;
    endfunction

    function automatic logic get_busy(input int s);
        return (s == 0) ? busy0 : busy1;
    endfunction

    // Pops the scoreboard for every handshake seen before the edge, then advances a cycle.
    task automatic cyc();
        if (!RST && yif0.y_valid && ready_v[0]) begin
            if (q0.size() == 0) check_val("sb0_depth", 64'(q0.size()), 64'd1);
            else                check_val("sb0_y_val", yif0.y_val, q0.pop_front());
        end
        if (!RST && yif1.y_valid && ready_v[1]) begin
            if (q1.size() == 0) check_val("sb1_depth", 64'(q1.size()), 64'd1);
            else                check_val("sb1_y_val", yif1.y_val, q1.pop_front());
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic start_pulse(input int s);
        start_v[s] = 1'b1;
        cyc();
        start_v[s] = 1'b0;
        check_val("busy_on", get_busy(s), 1'b1);
    endtask

    // Drives one full window; vh records y_valid after each of its eight edges.
    task automatic window(input int s, input int mode, input bit push, input logic [7:0] rdy,
                          input int start_k, output logic [7:0] vh);
        int         c0, c1;
        logic [1:0] p, m;
        c0 = 0;
        c1 = 0;
        for (int k = 0; k < WIN; k++) begin
            case (mode)
                0:       begin p = 2'b01;            m = 2'b10;            end
                1:       begin p = {1'b1, ~k[0]};    m = 2'b10;            end
                default: begin p = 2'b01;            m = {k[0], 1'b0};     end
            endcase
            x_p        = p;
            x_m        = m;
            ready_v[s] = rdy[k];
            start_v[s] = (k == start_k);
            c0 += int'(p[0]) - int'(m[0]);
            c1 += int'(p[1]) - int'(m[1]);
            cyc();
            vh[k] = get_valid(s);
        end
        start_v[s] = 1'b0;
        ready_v[s] = 1'b0;
        if (push) begin
            if (s == 0) q0.push_back(pack2(c0, c1));
            else        q1.push_back(pack2(c0, c1));
        end
    endtask

    initial begin
        logic [7:0] vh;

        cyc();
        cyc();
        check_val("rst_valid0", yif0.y_valid, 1'b0);
        check_val("rst_yval0",  yif0.y_val, {YW{1'b0}});
        check_val("rst_busy0",  busy0, 1'b0);
        check_val("rst_ovr0",   ovr0, 1'b0);
        check_val("rst_valid1", yif1.y_valid, 1'b0);
        check_val("rst_busy1",  busy1, 1'b0);
        check_val("rst_ovr1",   ovr1, 1'b0);
        RST = 1'b0;

        // Idle inputs must not leak into the first window.
        x_p = 2'b11;
        x_m = 2'b00;
        repeat (3) cyc();

        // One-shot window: +8 / -8, result exactly one cycle after the last sample.
        start_pulse(0);
        window(0, 0, 1'b1, 8'hFF, -1, vh);
        check_val("t1_vhist", vh, 8'b1000_0000);
        check_val("t1_busy_off", busy0, 1'b0);
        ready_v[0] = 1'b1;
        cyc();
        ready_v[0] = 1'b0;
        check_val("t1_consumed", yif0.y_valid, 1'b0);

        // Alternating ch0, p=m=1 on ch1; a start mid-window is ignored.
        start_pulse(0);
        window(0, 1, 1'b1, 8'hFF, 3, vh);
        check_val("t2_vhist", vh, 8'b1000_0000);
        ready_v[0] = 1'b1;
        cyc();
        ready_v[0] = 1'b0;
        check_val("t2_consumed", yif0.y_valid, 1'b0);
        check_val("t2_idle", busy0, 1'b0);

        // start together with stop while idle keeps the block idle.
        start_v[0] = 1'b1;
        stop_v[0]  = 1'b1;
        cyc();
        start_v[0] = 1'b0;
        stop_v[0]  = 1'b0;
        check_val("ss_busy", busy0, 1'b0);
        repeat (10) cyc();
        check_val("ss_no_out", yif0.y_valid, 1'b0);

        // Continuous, always ready: a one-cycle y_valid pulse per window, no gaps.
        start_pulse(1);
        for (int w = 0; w < 3; w++) begin
            window(1, 2, 1'b1, 8'hFF, -1, vh);
            check_val("t3_vhist", vh, 8'b1000_0000);
        end
        check_val("t3_busy", busy1, 1'b1);
        check_val("t3_ovr", ovr1, 1'b0);

        // Consumer stalls: second window end is dropped and flagged.
        window(1, 2, 1'b1, 8'b0000_0001, -1, vh);
        check_val("t4_vhist_a", vh, 8'b1000_0000);
        window(1, 0, 1'b0, 8'h00, -1, vh);
        check_val("t4_vhist_b", vh, 8'hFF);
        check_val("t4_ovr", ovr1, 1'b1);
        check_val("t4_held", yif1.y_val, pack2(8, -4));
        window(1, 1, 1'b1, 8'b0000_0001, -1, vh);
        check_val("t4_vhist_c", vh, 8'b1000_0000);

        // Reset mid-window discards the pending result and clears overrun.
        x_p = 2'b01;
        x_m = 2'b00;
        repeat (3) cyc();
        RST = 1'b1;
        cyc();
        check_val("rst_mid_valid", yif1.y_valid, 1'b0);
        check_val("rst_mid_yval",  yif1.y_val, {YW{1'b0}});
        check_val("rst_mid_busy",  busy1, 1'b0);
        check_val("rst_mid_ovr",   ovr1, 1'b0);
        q1.delete();
        RST = 1'b0;
        cyc();

        // Consume and window end on the same cycle: new result loads, no overrun.
        start_pulse(1);
        window(1, 0, 1'b1, 8'h00, -1, vh);
        check_val("t5_vhist_a", vh, 8'b1000_0000);
        window(1, 1, 1'b1, 8'b1000_0000, -1, vh);
        check_val("t5_vhist_b", vh, 8'hFF);
        check_val("t5_ovr", ovr1, 1'b0);

        // stop at wcnt=5: no output, idle, pending result kept.
        for (int k = 0; k < 6; k++) begin
            x_p       = 2'b01;
            x_m       = 2'b10;
            stop_v[1] = (k == 5);
            cyc();
        end
        stop_v[1] = 1'b0;
        check_val("t6_busy_a",  busy1, 1'b0);
        check_val("t6_valid_a", yif1.y_valid, 1'b1);
        check_val("t6_yval_a",  yif1.y_val, pack2(4, 0));
        repeat (2) cyc();
        check_val("t6_stay_idle", busy1, 1'b0);

        // stop on the last sample: still no snapshot.
        start_pulse(1);
        for (int k = 0; k < WIN; k++) begin
            stop_v[1] = (k == WIN - 1);
            cyc();
        end
        stop_v[1] = 1'b0;
        check_val("t6_busy_b",  busy1, 1'b0);
        check_val("t6_valid_b", yif1.y_valid, 1'b1);
        check_val("t6_yval_b",  yif1.y_val, pack2(4, 0));
        check_val("t6_ovr_b",   ovr1, 1'b0);

        ready_v[1] = 1'b1;
        cyc();
        cyc();
        ready_v[1] = 1'b0;
        check_val("drain_valid", yif1.y_valid, 1'b0);
        check_val("sb0_left", 64'(q0.size()), 64'd0);
        check_val("sb1_left", 64'(q1.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
